qpsk_tx_seq: RTL

QPSK_TX_SEQ -- requirements
Module: qpsk_tx_seq

---
 rtl/qpsk_tx_pkg.sv | 22 ++
 rtl/qpsk_tx_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/qpsk_tx_pkg.sv
// Shared definitions for the QPSK transmit frame sequencer: one-hot state
// encoding, default frame constants and the header word builder.
package qpsk_tx_pkg;

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_PRE  = 6'b000010,
    ST_SYNC = 6'b000100,
    ST_HDR  = 6'b001000,
    ST_PAY  = 6'b010000,
    ST_END  = 6'b100000
  } state_t;

  localparam logic [31:0] PRE_PATTERN_DEF = 32'hCCCCCCCC;
  localparam logic [31:0] SYNC_WORD_DEF   = 32'h1ACFFC1D;
  localparam logic [15:0] HDR_TAG_DEF     = 16'hA55A;

  function automatic logic [31:0] hdr_word(input logic [15:0] tag, input logic [7:0] len);
    return {tag, 8'h00, len};
  endfunction

endpackage

// File: rtl/qpsk_tx_seq.sv
// Frame sequencer feeding a QPSK slicer: preamble, sync word, header, then
// len payload words pulled from a valid/ack source, one word per slicer ack.
module qpsk_tx_seq
  import qpsk_tx_pkg::*;
#(
  parameter int unsigned PRE_WORDS   = 2,
  parameter logic [31:0] PRE_PATTERN = PRE_PATTERN_DEF,
  parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter logic [15:0] HDR_TAG     = HDR_TAG_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  input  logic        pay_valid,
  input  logic [31:0] pay_data,
  output logic        pay_ack,
  output logic        slc_valid,
  output logic [31:0] slc_data,
  input  logic        slc_ack
);

  localparam logic [7:0] LP_PRE_LAST = 8'(PRE_WORDS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_len;
  logic [7:0]  w_len_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_cnt_inc;
  logic [31:0] r_data;
  logic [31:0] w_data_nxt;
  logic        r_vld;
  logic        w_vld_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_pay_ack;
  logic        w_load;
  logic        r_underrun;
  logic        w_underrun_nxt;
  logic        w_adv;
  logic        w_take;

  assign w_adv     = r_vld & slc_ack;
  assign w_cnt_inc = r_cnt + 8'd1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_vld      <= 1'b0;
      r_done     <= 1'b0;
      r_pay_ack  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data     <= w_data_nxt;
      r_vld      <= w_vld_nxt;
      r_done     <= w_done_nxt;
      r_pay_ack  <= w_load;
      r_underrun <= w_underrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_cnt_nxt      = r_cnt;
    w_data_nxt     = r_data;
    w_vld_nxt      = r_vld;
    w_done_nxt     = 1'b0;
    w_underrun_nxt = r_underrun;
    w_take         = 1'b0;
    w_load         = 1'b0;

    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_vld_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            w_state_nxt    = ST_PRE;
            w_len_nxt      = len;
            w_data_nxt     = PRE_PATTERN;
            w_vld_nxt      = 1'b1;
            w_underrun_nxt = 1'b0;
            w_cnt_nxt      = '0;
          end
        end
        ST_PRE: begin
          if (w_adv) begin
            if (r_cnt == LP_PRE_LAST) begin
              w_state_nxt = ST_SYNC;
              w_cnt_nxt   = '0;
              w_data_nxt  = SYNC_WORD;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end
        end
        ST_SYNC: begin
          if (w_adv) begin
            w_state_nxt = ST_HDR;
            w_data_nxt  = hdr_word(HDR_TAG, r_len);
          end
        end
        // The header ack already fetches payload word 1 so the slicer never idles.
        ST_HDR: begin
          if (w_adv) begin
            if (r_len == 8'd0) begin
              w_state_nxt = ST_END;
              w_vld_nxt   = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_PAY;
              w_take      = 1'b1;
            end
          end
        end
        ST_PAY: begin
          if (w_adv) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              w_state_nxt = ST_END;
              w_vld_nxt   = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_take      = 1'b1;
            end
          end else if (!r_vld) begin
            w_take = 1'b1;
          end
        end
        ST_END: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_vld_nxt   = 1'b0;
        end
      endcase
    end

    if (w_take) begin
      if (pay_valid) begin
        w_data_nxt = pay_data;
        w_vld_nxt  = 1'b1;
        w_load     = 1'b1;
      end else begin
        w_vld_nxt      = 1'b0;
        w_underrun_nxt = 1'b1;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign underrun  = r_underrun;
  assign pay_ack   = r_pay_ack;
  assign slc_valid = r_vld;
  assign slc_data  = r_data;

endmodule
